instr_fetch: RTL

Instruction-fetch stage of the multicycle processor: on request from the control FSM it reads one 8-bit instruction from memory at the current PC, captures it in the instruction register (IR), and advances the PC. Sits directly upstream of the zero/sign extenders: its immediate-field outputs (imm3, imm4, imm5) are the extenders' `in` operands, and the register fields feed the register file.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/instr_fetch_if.sv | 34 +++
 rtl/fetch_timer.sv | 27 ++
 rtl/instr_fetch.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states,
// instruction-field bit positions, and the default memory wait limit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int R1_MSB     = 7;
  localparam int R1_LSB     = 6;
  localparam int R2_MSB     = 5;
  localparam int R2_LSB     = 4;
  localparam int OPCODE_MSB = 3;
  localparam int OPCODE_LSB = 0;
  localparam int IMM3_MSB   = 5;
  localparam int IMM3_LSB   = 3;
  localparam int IMM4_MSB   = 7;
  localparam int IMM4_LSB   = 4;
  localparam int IMM5_MSB   = 7;
  localparam int IMM5_LSB   = 3;

  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: control requests, memory read port, IR and decoded fields.
// master = fetch unit side, slave = control FSM / memory / decode side.
interface instr_fetch_if #(parameter int PC_W = 8);
  logic            fetch;
  logic            pc_ld;
  logic [PC_W-1:0] pc_in;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rdy;
  logic [7:0]      mem_data;
  logic [7:0]      ir;
  logic            ir_valid;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            fault;
  logic [1:0]      r1;
  logic [1:0]      r2;
  logic [3:0]      opcode;
  logic [2:0]      imm3;
  logic [3:0]      imm4;
  logic [4:0]      imm5;

  modport master (
    input  fetch, pc_ld, pc_in, mem_rdy, mem_data,
    output mem_rd, mem_addr, ir, ir_valid, pc, busy, fault,
           r1, r2, opcode, imm3, imm4, imm5
  );

  modport slave (
    output fetch, pc_ld, pc_in, mem_rdy, mem_data,
    input  mem_rd, mem_addr, ir, ir_valid, pc, busy, fault,
           r1, r2, opcode, imm3, imm4, imm5
  );
endinterface

// File: rtl/fetch_timer.sv
// Saturating memory-wait counter; o_expire is high during the cycle whose
// stall would bring the count to LIMIT, so the FSM can leave REQ on that edge.
module fetch_timer #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_cnt,
  output logic o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_cnt && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_cnt && (r_cnt >= 8'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one byte per request, IR/PC update two edges after fetch at best,
// stalls in REQ while mem_rdy is low. FETCH_TIMEOUT_EN adds a wait limit into FAULT.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clock,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT must be in 1..255");
  end

  fetch_state_t    r_state, w_state;
  logic [PC_W-1:0] r_pc, w_pc;
  logic [PC_W-1:0] r_pend, w_pend;
  logic            r_pend_vld, w_pend_vld;
  logic [7:0]      r_ir, w_ir;
  logic            r_ir_valid, w_ir_valid;
  logic            w_expire;

`ifdef FETCH_TIMEOUT_EN
  logic w_tmr_clr;
  logic w_tmr_cnt;

  assign w_tmr_clr = (r_state == IDLE) && bus.fetch;
  assign w_tmr_cnt = (r_state == REQ) && !bus.mem_rdy;

  fetch_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clr    (w_tmr_clr),
    .i_cnt    (w_tmr_cnt),
    .o_expire (w_expire)
  );

  assign bus.fault = (r_state == FAULT);
`else
  assign w_expire  = 1'b0;
  assign bus.fault = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_ir       <= 8'h00;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_pend     <= w_pend;
      r_pend_vld <= w_pend_vld;
      r_ir       <= w_ir;
      r_ir_valid <= w_ir_valid;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_pend     = r_pend;
    w_pend_vld = r_pend_vld;
    w_ir       = r_ir;
    w_ir_valid = r_ir_valid;
    unique case (r_state)
      IDLE: begin
        if (bus.fetch) begin
          w_state    = REQ;
          w_ir_valid = 1'b0;
          if (bus.pc_ld) begin
            w_pend     = bus.pc_in;
            w_pend_vld = 1'b1;
          end
        end else if (bus.pc_ld) begin
          w_pc = bus.pc_in;
        end
      end
      REQ: begin
        // A load arriving in the completing cycle is newest and wins.
        if (bus.pc_ld) begin
          w_pend     = bus.pc_in;
          w_pend_vld = 1'b1;
        end
        if (bus.mem_rdy) begin
          w_state    = IDLE;
          w_ir       = bus.mem_data;
          w_ir_valid = 1'b1;
          w_pc       = w_pend_vld ? w_pend : (r_pc + PC_W'(1));
          w_pend_vld = 1'b0;
        end else if (w_expire) begin
          w_state    = FAULT;
          w_pend_vld = 1'b0;
        end
      end
      FAULT: begin
        if (bus.pc_ld) begin
          w_state = IDLE;
          w_pc    = bus.pc_in;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.mem_rd   = (r_state == REQ);
  assign bus.busy     = (r_state != IDLE);
  assign bus.mem_addr = r_pc;
  assign bus.pc       = r_pc;
  assign bus.ir       = r_ir;
  assign bus.ir_valid = r_ir_valid;
  assign bus.r1       = r_ir[R1_MSB:R1_LSB];
  assign bus.r2       = r_ir[R2_MSB:R2_LSB];
  assign bus.opcode   = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign bus.imm3     = r_ir[IMM3_MSB:IMM3_LSB];
  assign bus.imm4     = r_ir[IMM4_MSB:IMM4_LSB];
  assign bus.imm5     = r_ir[IMM5_MSB:IMM5_LSB];

endmodule
